// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM states, register offsets, STATUS bit positions.
// UART_TX_PARITY_EN adds the PARITY state used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [2:0] UART_DATA_OFS   = 3'h0;
    localparam logic [2:0] UART_STATUS_OFS = 3'h4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_PAR_BIT   = 4;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; push while full is dropped, pop while empty is ignored.
// Storage is not reset, only pointers and count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: DATA pushes bytes into a FIFO, STATUS reports space/busy/overflow,
// and a baud serializer sends 8N1 frames. Define UART_TX_PARITY_EN for an even-parity bit (8E1).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CLK_DIV    = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wenable,
    output logic [31:0] data_rdata,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    uart_state_t     state;
    uart_state_t     state_d;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tick;
    logic            overflow;

    logic [31:0]     offset;
    logic [2:0]      reg_ofs;
    logic            wr;
    logic            push;
    logic            clr_ovf;
    logic            fifo_pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [15:0]     count_ext;
    logic [31:0]     status;
    logic            unused_bits;

    // Window decode by subtraction so BASE_ADDR need only be word aligned.
    assign offset  = data_addr - BASE_ADDR;
    assign sel     = (offset < 32'd8);
    assign reg_ofs = {offset[2], 2'b00};
    assign wr      = sel & data_wenable[0];
    assign push    = wr & (reg_ofs == UART_DATA_OFS);
    assign clr_ovf = wr & (reg_ofs == UART_STATUS_OFS) & data_wdata[3];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign busy      = (fifo_count != '0) | (state != ST_IDLE);
    assign count_ext = 16'(fifo_count);

    always_comb begin
        status                 = '0;
        status[STAT_FULL_BIT]  = fifo_full;
        status[STAT_EMPTY_BIT] = fifo_empty;
        status[STAT_BUSY_BIT]  = busy;
        status[STAT_OVF_BIT]   = overflow;
`ifdef UART_TX_PARITY_EN
        status[STAT_PAR_BIT]   = 1'b1;
`endif
        status[STAT_COUNT_LSB +: 8] = count_ext[7:0];
    end

    assign data_rdata  = (sel && reg_ofs == UART_STATUS_OFS) ? status : 32'h0;
    assign unused_bits = ^{data_wdata[31:8], data_wenable[3:1], offset[1:0], count_ext[15:8]};

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_idx <= '0;
        end else if (fifo_pop || state == ST_IDLE) begin
            div_cnt <= '0;
            bit_idx <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (state == ST_DATA && tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            shreg <= fifo_rdata;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg[bit_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = ^shreg;
`endif
            default:   tx = 1'b1;
        endcase
    end

endmodule
